// File: rtl/mem_0_pkg.sv
// Shared m0_m1 field widths, the ADDR_LSB default and small helpers used by
// mem_0 and Mem_1.
package mem_0_pkg;

  localparam int unsigned M0_DATA_W       = 32;
  localparam int unsigned M0_REGDEST_W    = 5;
  localparam int unsigned M0_IMM_W        = 16;
  localparam int unsigned M0_NUM_REGS     = 32;
  localparam int unsigned M0_ADDR_LSB_DEF = 2;

  typedef struct packed {
    logic                    oper;
    logic                    readmem;
    logic                    writemem;
    logic                    writereg;
    logic [M0_DATA_W-1:0]    data_addr;
    logic [M0_DATA_W-1:0]    regb;
    logic [M0_REGDEST_W-1:0] regdest;
  } m0_m1_t;

  typedef struct packed {
    logic                    valid;
    logic [M0_REGDEST_W-1:0] dest;
  } ld_slot_t;

  function automatic logic [M0_DATA_W-1:0] sext_imm(input logic [M0_IMM_W-1:0] imm);
    return {{(M0_DATA_W-M0_IMM_W){imm[M0_IMM_W-1]}}, imm};
  endfunction

  // r0 is hard-wired, so a slot naming it never contributes a mask bit.
  function automatic logic [M0_NUM_REGS-1:0] slot_onehot(input ld_slot_t s);
    logic [M0_NUM_REGS-1:0] m;
    m = {M0_NUM_REGS{1'b0}};
    if (s.valid && (s.dest != {M0_REGDEST_W{1'b0}})) begin
      m[s.dest] = 1'b1;
    end else begin
      m = {M0_NUM_REGS{1'b0}};
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_0_if.sv
// Issue-to-mem_0 operation bundle and the m0_m1 pipeline register bundle.
interface mem_0_if;
  import mem_0_pkg::*;

  logic                    is_m0_oper;
  logic                    is_m0_readmem;
  logic                    is_m0_writemem;
  logic [M0_DATA_W-1:0]    is_m0_rega;
  logic [M0_IMM_W-1:0]     is_m0_imm;
  logic [M0_DATA_W-1:0]    is_m0_regb;
  logic [M0_REGDEST_W-1:0] is_m0_regdest;
  logic                    is_m0_writereg;

  logic                    m0_m1_oper;
  logic                    m0_m1_readmem;
  logic                    m0_m1_writemem;
  logic                    m0_m1_writereg;
  logic [M0_DATA_W-1:0]    m0_m1_data_addr;
  logic [M0_DATA_W-1:0]    m0_m1_regb;
  logic [M0_REGDEST_W-1:0] m0_m1_regdest;

  modport master (
    output is_m0_oper, is_m0_readmem, is_m0_writemem, is_m0_rega, is_m0_imm,
           is_m0_regb, is_m0_regdest, is_m0_writereg,
    input  m0_m1_oper, m0_m1_readmem, m0_m1_writemem, m0_m1_writereg,
           m0_m1_data_addr, m0_m1_regb, m0_m1_regdest
  );

  modport slave (
    input  is_m0_oper, is_m0_readmem, is_m0_writemem, is_m0_rega, is_m0_imm,
           is_m0_regb, is_m0_regdest, is_m0_writereg,
    output m0_m1_oper, m0_m1_readmem, m0_m1_writemem, m0_m1_writereg,
           m0_m1_data_addr, m0_m1_regb, m0_m1_regdest
  );

endinterface

// File: rtl/mem_0_load_tracker.sv
// Two-deep load-destination tracker: slot A holds the load in mem_0's output,
// slot B the one now in Mem_1; the pending mask is their onehot union.
module load_tracker
  import mem_0_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    i_load_valid,
  input  logic [M0_REGDEST_W-1:0] i_load_dest,
  output logic [M0_NUM_REGS-1:0]  o_pending_mask
);

  ld_slot_t r_slot_a;
  ld_slot_t r_slot_b;
  ld_slot_t w_slot_a_nxt;

  // Next slot A content; dest is kept at zero when nothing is tracked.
  always_comb begin
    w_slot_a_nxt = '0;
    if (i_load_valid) begin
      w_slot_a_nxt.valid = 1'b1;
      w_slot_a_nxt.dest  = i_load_dest;
    end else begin
      w_slot_a_nxt = '0;
    end
  end

  // Slot shift register; flush squashes both stages of tracking.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_slot_a <= '0;
      r_slot_b <= '0;
    end else if (flush) begin
      r_slot_a <= '0;
      r_slot_b <= '0;
    end else begin
      r_slot_a <= w_slot_a_nxt;
      r_slot_b <= r_slot_a;
    end
  end

  assign o_pending_mask = slot_onehot(r_slot_a) | slot_onehot(r_slot_b);

endmodule

// File: rtl/mem_0.sv
// First data-memory stage: effective address, m0_m1 pipeline register and
// load-use tracker. Optional misaligned-access trap: MEM0_MISALIGN_TRAP_EN.
module mem_0
  import mem_0_pkg::*;
#(
  parameter int unsigned ADDR_LSB = M0_ADDR_LSB_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  mem_0_if.slave                 m0_if,
  output logic [M0_NUM_REGS-1:0] m0_pending_mask,
  output logic                   m0_misalign
);

`ifdef MEM0_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic [M0_DATA_W-1:0] w_eff_addr;
  logic                 w_is_load;
  logic                 w_is_store;
  logic                 w_misaligned;
  logic                 w_accept;
  logic                 w_track_valid;
  m0_m1_t               w_stage_nxt;
  m0_m1_t               r_stage;
  logic                 r_misalign;

  assign w_eff_addr = m0_if.is_m0_rega + sext_imm(m0_if.is_m0_imm);

  // Read+write together is illegal and degrades to a plain load.
  assign w_is_load  = m0_if.is_m0_readmem;
  assign w_is_store = m0_if.is_m0_writemem & ~m0_if.is_m0_readmem;

  assign w_misaligned = TRAP_EN & m0_if.is_m0_oper & (w_is_load | w_is_store)
                      & (w_eff_addr[ADDR_LSB-1:0] != {ADDR_LSB{1'b0}});

  assign w_accept      = m0_if.is_m0_oper & ~flush & ~w_misaligned;
  assign w_track_valid = w_accept & w_is_load & m0_if.is_m0_writereg
                       & (m0_if.is_m0_regdest != {M0_REGDEST_W{1'b0}});

  // Next pipeline-register content; anything not accepted becomes a bubble.
  always_comb begin
    w_stage_nxt = '0;
    if (w_accept) begin
      w_stage_nxt.oper      = 1'b1;
      w_stage_nxt.readmem   = w_is_load;
      w_stage_nxt.writemem  = w_is_store;
      w_stage_nxt.writereg  = m0_if.is_m0_writereg;
      w_stage_nxt.data_addr = w_eff_addr;
      w_stage_nxt.regb      = m0_if.is_m0_regb;
      w_stage_nxt.regdest   = m0_if.is_m0_regdest;
    end else begin
      w_stage_nxt = '0;
    end
  end

  // m0_m1 pipeline register and misalign pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stage    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_stage    <= w_stage_nxt;
      r_misalign <= w_misaligned & ~flush;
    end
  end

  load_tracker u_load_tracker (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .i_load_valid   (w_track_valid),
    .i_load_dest    (m0_if.is_m0_regdest),
    .o_pending_mask (m0_pending_mask)
  );

  assign m0_if.m0_m1_oper      = r_stage.oper;
  assign m0_if.m0_m1_readmem   = r_stage.readmem;
  assign m0_if.m0_m1_writemem  = r_stage.writemem;
  assign m0_if.m0_m1_writereg  = r_stage.writereg;
  assign m0_if.m0_m1_data_addr = r_stage.data_addr;
  assign m0_if.m0_m1_regb      = r_stage.regb;
  assign m0_if.m0_m1_regdest   = r_stage.regdest;
  assign m0_misalign           = r_misalign;

endmodule

// File: doc/mem_0.md
# mem_0

First data-memory pipeline stage. It accepts a memory or ALU-pass-through operation from the issue stage and computes the effective address (base + sign-extended offset). It drives the `m0_m1_*` pipeline register consumed by `Mem_1`, and keeps a two-deep load-destination tracker so issue can block load-use hazards. It sits between issue and `Mem_1` and is the producer end of the `m0_m1` interface.

## Interface
Parameters:
- `ADDR_LSB`, default 2, byte-address bit where the word index starts; alignment is checked on bits below it.

Ports (clock and reset first):
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of the stage contents and the tracker.
- `is_m0_oper`  in  1  issue slot holds a valid operation.
- `is_m0_readmem`  in  1  operation is a load.
- `is_m0_writemem`  in  1  operation is a store.
- `is_m0_rega`  in  32  base register value.
- `is_m0_imm`  in  16  signed address offset.
- `is_m0_regb`  in  32  store data.
- `is_m0_regdest`  in  5  destination register.
- `is_m0_writereg`  in  1  operation writes a register.
- `m0_m1_oper`, `m0_m1_readmem`, `m0_m1_writemem`, `m0_m1_writereg`  out  1 each  registered control to `Mem_1`.
- `m0_m1_data_addr`  out  32  registered effective byte address.
- `m0_m1_regb`  out  32  registered store data.
- `m0_m1_regdest`  out  5  registered destination.
- `m0_pending_mask`  out  32  bit r set means a load to r is in `mem_0` output or in `Mem_1`.
- `m0_misalign`  out  1  registered one-cycle pulse on a squashed misaligned access.

## Operation
- Effective address: `is_m0_rega + {{16{imm[15]}}, imm}`, computed modulo 2^32; carry is discarded.
- Illegal control: `readmem` and `writemem` both set is treated as a load with `writemem` forced to 0.
- Accept rule: every cycle, with `is_m0_oper`=1 and no flush, the inputs are captured into the `m0_m1_*` registers. With `is_m0_oper`=0, all `m0_m1_*` outputs are loaded with zero.
- The stage has no stall. Issue must not present an operation that reads a register whose `m0_pending_mask` bit is set.
- Tracker: two slots, each holding valid + 5-bit dest.
  - Slot A is written on accept with valid = load & writereg & regdest≠0.
  - Slot B is loaded from slot A every cycle.
  - `m0_pending_mask` = onehot(A) | onehot(B), built combinationally from registered slots. Register 0 is never set.
  - The same dest in A and B gives a single bit.
- Flush: for one edge, `m0_m1_*` and both tracker slots are zeroed. Flush has priority over accept.
- Reset (async, asserted low): all outputs and slots go to 0 immediately.
  - The first edge after release with `is_m0_oper`=1 is a normal accept.

## Timing
- Latency: input to `m0_m1_*` is 1 cycle; `m0_misalign` is 1 cycle.
- Mask timeline for a load accepted at edge N:
  - its bit sets after edge N;
  - it stays set through edge N+1, while `Mem_1` registers the writeback;
  - it clears after edge N+2, when the writeback value is architecturally available.
- Back-to-back loads to the same register keep the bit set continuously until 2 edges after the last one.
- Reset values: every output is 0, including `m0_pending_mask` = 32'h0.

## Configuration
- `MEM0_MISALIGN_TRAP_EN` defined:
  - a load or store with `addr[ADDR_LSB-1:0]≠0` is squashed, so `m0_m1_*` loads zeros and no tracker entry is made;
  - `m0_misalign` pulses high for 1 cycle.
- Not defined:
  - low address bits pass through unchanged; `Mem_1` ignores them;
  - `m0_misalign` is tied to 0.

## Structure
- Shared package or include holds the `m0_m1` field widths (data 32, regdest 5, imm 16) and the `ADDR_LSB` default. These are shared with `Mem_1`.
- One sub-module, `load_tracker`: holds the two slots and flush, and produces the onehot mask. The address adder and pipeline register stay in the top.

## Test plan
- Load: rega=32'h100, imm=16'hFFFC, dest=5, writereg=1 → next cycle `m0_m1_data_addr`=32'hFC, readmem=1; mask=32'h20 for exactly 2 cycles, then 0.
- Store: rega=32'h40, imm=8, regb=32'hDEADBEEF → `m0_m1_writemem`=1, addr=32'h48, regb=32'hDEADBEEF; mask stays 0.
- Load to r0, and an ALU op with writereg=1 to r3 → mask stays 32'h0 for both.
- With `MEM0_MISALIGN_TRAP_EN`, load with addr=32'h102 → all `m0_m1_*`=0, `m0_misalign`=1 for one cycle, mask 0. Without the macro → addr=32'h102 passes through, misalign=0.
- Load dest=7 accepted, then `flush` on the next cycle → mask 0 and `m0_m1_oper`=0 after the flush edge.
- Assert `reset` low between clock edges while a load is pending → outputs and mask drop to 0 before the next edge.
